cpu_axi_bridge: RTL and testbench
=================================

Name: cpu_axi_bridge

Overview:
Sits directly below the CPU core. It converts the core's two SRAM-like request/addr_ok/data_ok ports (instruction and data) into a single AXI3 master with one read channel and one write channel. Data reads are arbitrated against instruction reads on AR, and data writes go out on AW/W/B. The bridge allows at most one outstanding read and one outstanding write, and at most one outstanding data-side transaction in total.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
inst_req  in  1  instruction read request
inst_addr  in  32  instruction address
inst_rdata  out  32  instruction read data
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction data valid this cycle
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte strobes for writes
data_addr  in  32  data address
data_size  in  3  AXI size encoding (0 = byte, 1 = half, 2 = word)
data_wdata  in  32  write data
data_rdata  out  32  data read data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  read data valid or write response received
arid  out  4  0 = instruction, 1 = data
araddr  out  32  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  read response ID
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Len/burst/lock/cache/prot/wlast/awid are not ported. The interconnect wrapper ties them to single-beat INCR, wlast = 1, awid = 1.

Behaviour:
- Reset values: all valid/ready/ok outputs 0; address, size, ID and data registers 0; both FSMs in IDLE.
- Reset asserted mid-transaction: immediate abort, no data_ok is produced, FSMs return to IDLE.
- Read FSM states: R_IDLE, R_AR, R_R.
  - R_IDLE: a data read (data_req & !data_wr & no data write outstanding) takes priority over inst_req.
  - The winner's addr_ok is driven combinationally in the same cycle. The loser's addr_ok stays 0.
  - On acceptance, latch address, size and ID, then go to R_AR. Instruction reads always use arsize = 2.
  - R_AR: arvalid = 1 and held stable until arready, then go to R_R.
  - R_R: rready = 1. On rvalid, rdata passes through combinationally to inst_rdata and data_rdata.
    - rid = 0: pulse inst_data_ok.
    - rid = 1: pulse data_data_ok.
    - Either way, return to R_IDLE next cycle.
  - No new read is accepted in the cycle the response arrives.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: accept data_req & data_wr when the read FSM holds no data read. Drive data_addr_ok combinationally, latch addr, size, wdata and wstrb, then go to W_ADDR.
  - W_ADDR: awvalid and wvalid are both raised in the same cycle. Two flags, aw_done and w_done, track each handshake independently. The order of awready and wready is arbitrary and they may coincide. Go to W_RESP once both are done.
  - W_RESP: bready = 1. On bvalid, pulse data_data_ok and return to W_IDLE.
- Data-side exclusivity:
  - data_addr_ok is never asserted while any data read or write is outstanding.
  - Therefore read-side and write-side data_data_ok pulses never coincide.
- Concurrency: an instruction read may proceed while a data write is in W_ADDR or W_RESP.
- Same-cycle arbitration: if inst_req and a data read arrive together, the data read wins. inst_addr_ok = 0, and the core keeps inst_req asserted.
- Timing: minimum latency from addr_ok to data_ok is 2 cycles (AR handshake 1 cycle after accept, response 1 cycle after that).
- Output stability: all AXI valid outputs are registered and held until their handshake.

Test Plan:
- Single instruction read: inst_req = 1, inst_addr = 0xBFC00000; arready on first arvalid; rvalid, rid = 0, rdata = 0x3C1D8000 two cycles later → inst_addr_ok in cycle 0, arid = 0, arsize = 2, inst_data_ok pulse with inst_rdata = 0x3C1D8000.
- Arbitration: inst_req and data read to 0x80001000 asserted in the same cycle → data_addr_ok = 1, inst_addr_ok = 0, araddr = 0x80001000, arid = 1. The instruction read is issued after data_data_ok.
- Write with W-before-AW: data_wr = 1, addr 0x80002004, wstrb = 0x3, size = 1, wdata = 0x0000BEEF; wready asserted 3 cycles before awready → exactly one data_data_ok, only after bvalid; awsize = 1, wstrb = 0x3.
- Overlap: data write stalled in W_RESP (bvalid withheld 10 cycles) with an instruction read issued meanwhile → inst_data_ok completes first; a further data_req sees data_addr_ok = 0 until bvalid.
- Reset mid-read: assert reset while in R_R before rvalid → arvalid, rready and all ok outputs drop to 0 immediately; after release, the first new inst_req is accepted in cycle 0.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-like instruction and data ports onto one AXI3 master.
// It allows one outstanding read, one outstanding write, and one data-side transaction at a time.
module cpu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [2:0]          data_size,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready,
  output logic [1:0]          rd_state_dbg,
  output logic [1:0]          wr_state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid is raised from a register, held with its payload stable until that edge, and
  // never waits on ready. The core-side addr_ok/data_ok are single-cycle strobes.

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_t;

  rd_state_t r_state;
  wr_state_t w_state;
  logic      aw_done;
  logic      w_done;
  logic      data_rd_busy;
  logic      data_rd_go;
  logic      data_wr_go;
  logic      inst_go;
  logic      aw_hs;
  logic      w_hs;

  // arid still holds the ID of the read in flight, so it tells us whether that read is a data read.
  assign data_rd_busy = (r_state != R_IDLE) && (arid == 4'd1);
  assign data_rd_go   = !reset && (r_state == R_IDLE) && data_req && !data_wr && (w_state == W_IDLE);
  assign inst_go      = !reset && (r_state == R_IDLE) && inst_req && !data_rd_go;
  assign data_wr_go   = !reset && (w_state == W_IDLE) && data_req && data_wr && !data_rd_busy;

  assign inst_addr_ok = inst_go;
  assign data_addr_ok = data_rd_go || data_wr_go;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = (r_state == R_R) && rvalid && (rid == 4'd0);
  assign data_data_ok = ((r_state == R_R) && rvalid && (rid == 4'd1)) ||
                        ((w_state == W_RESP) && bvalid);

  assign aw_hs        = awvalid && awready;
  assign w_hs         = wvalid && wready;
  assign rd_state_dbg = r_state;
  assign wr_state_dbg = w_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      araddr  <= '0;
      arsize  <= '0;
      arid    <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_go) begin
            araddr  <= data_addr;
            arsize  <= data_size;
            arid    <= 4'd1;
            arvalid <= 1'b1;
            r_state <= R_AR;
          end else if (inst_go) begin
            araddr  <= inst_addr;
            arsize  <= 3'd2;
            arid    <= 4'd0;
            arvalid <= 1'b1;
            r_state <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_go) begin
            awaddr  <= data_addr;
            awsize  <= data_size;
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: a delay-configurable AXI slave, queue scoreboards for
// AR/AW/W beats and for core-side responses, plus directed and random scenarios.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [2:0]  data_size;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  rd_state_dbg;
  logic [1:0]  wr_state_dbg;

  cpu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_ar_q[$];
  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_w_q[$];
  logic [31:0] inst_exp_q[$];
  logic [32:0] data_exp_q[$];   // bit 32 set = write response

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr_ok = 0;
  int n_drd_ok = 0;
  int last_inst_ok_cyc = 0;
  int acc_cyc = 0;

  int ar_delay = 0;
  int r_delay  = 0;
  int aw_delay = 0;
  int w_delay  = 0;
  int b_delay  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_8000;
    return a ^ 32'hA5A5_1234;
  endfunction

  // ---------------- AXI slave: read side ----------------
  initial begin
    logic [3:0]  cap_id;
    logic [31:0] cap_addr;
    bit          aborted;
    int          n;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && arvalid) begin
        for (int i = 0; i < ar_delay; i++) @(negedge clk);
        check("arvalid_held", {63'd0, arvalid}, 64'd1);
        arready = 1'b1;
        if (exp_ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else check("ar_beat", {25'd0, arid, arsize, araddr}, exp_ar_q.pop_front());
        cap_id = arid;
        cap_addr = araddr;
        @(negedge clk);
        arready = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < r_delay; i++) begin
          @(negedge clk);
          if (reset) begin aborted = 1'b1; break; end
        end
        if (!aborted && !reset) begin
          rvalid = 1'b1;
          rid = cap_id;
          rdata = rdata_for(cap_addr);
          n = 0;
          while (!rready && n < 50) begin @(negedge clk); n++; end
          if (n >= 50) check("r_hs_timeout", 64'd1, 64'd0);
          @(negedge clk);
          rvalid = 1'b0;
        end
      end
    end
  end

  // ---------------- AXI slave: write side ----------------
  initial begin
    int n;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && (awvalid || wvalid)) begin
        fork
          begin
            for (int i = 0; i < aw_delay; i++) @(negedge clk);
            check("awvalid_held", {63'd0, awvalid}, 64'd1);
            awready = 1'b1;
            if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else check("aw_beat", {29'd0, awsize, awaddr}, exp_aw_q.pop_front());
            @(negedge clk);
            awready = 1'b0;
          end
          begin
            for (int i = 0; i < w_delay; i++) @(negedge clk);
            check("wvalid_held", {63'd0, wvalid}, 64'd1);
            wready = 1'b1;
            if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else check("w_beat", {28'd0, wstrb, wdata}, exp_w_q.pop_front());
            @(negedge clk);
            wready = 1'b0;
          end
        join
        for (int i = 0; i < b_delay; i++) @(negedge clk);
        bvalid = 1'b1;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("b_hs_timeout", 64'd1, 64'd0);
        @(negedge clk);
        bvalid = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [32:0] mon_e;
  always @(negedge clk) begin
    #2;
    if (inst_data_ok) begin
      last_inst_ok_cyc = cyc;
      if (inst_exp_q.size() == 0) check("inst_ok_unexpected", 64'd1, 64'd0);
      else check("inst_rdata", {32'd0, inst_rdata}, {32'd0, inst_exp_q.pop_front()});
    end
    if (data_data_ok) begin
      if (data_exp_q.size() == 0) check("data_ok_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = data_exp_q.pop_front();
        if (mon_e[32]) begin
          check("wr_ok_needs_bvalid", {63'd0, bvalid}, 64'd1);
          n_wr_ok++;
        end else begin
          check("data_rdata", {32'd0, data_rdata}, {32'd0, mon_e[31:0]});
          n_drd_ok++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic inst_read(input logic [31:0] addr, output int wc);
    @(negedge clk);
    inst_req = 1'b1;
    inst_addr = addr;
    wc = 0;
    #1;
    while (!inst_addr_ok && wc < 100) begin @(negedge clk); #1; wc++; end
    if (inst_addr_ok) begin
      exp_ar_q.push_back({25'd0, 4'd0, 3'd2, addr});
      inst_exp_q.push_back(rdata_for(addr));
      acc_cyc = cyc;
    end else check("inst_accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    inst_req = 1'b0;
  endtask

  task automatic data_op(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] strb, input logic [31:0] wd, output int wc);
    @(negedge clk);
    data_req = 1'b1; data_wr = wr; data_addr = addr;
    data_size = size; data_wstrb = strb; data_wdata = wd;
    wc = 0;
    #1;
    while (!data_addr_ok && wc < 100) begin @(negedge clk); #1; wc++; end
    if (data_addr_ok) begin
      if (wr) begin
        exp_aw_q.push_back({29'd0, size, addr});
        exp_w_q.push_back({28'd0, strb, wd});
        data_exp_q.push_back({1'b1, 32'd0});
      end else begin
        exp_ar_q.push_back({25'd0, 4'd1, size, addr});
        data_exp_q.push_back({1'b0, rdata_for(addr)});
      end
    end else check("data_accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    data_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    int left;
    n = 0;
    left = inst_exp_q.size() + data_exp_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size();
    while (left != 0 && n < 300) begin
      @(negedge clk);
      n++;
      left = inst_exp_q.size() + data_exp_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size();
    end
    check(tag, left, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wc;
    int wc2;
    int n;
    int n0;
    int kind;
    logic [31:0] a;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0;
    data_size = '0; data_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
    check("rst_oks", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 64'd0);
    check("rst_ar_regs", {25'd0, arid, arsize, araddr}, 64'd0);
    check("rst_aw_regs", {29'd0, awsize, awaddr}, 64'd0);
    check("rst_w_regs", {28'd0, wstrb, wdata}, 64'd0);
    check("rst_states", {60'd0, rd_state_dbg, wr_state_dbg}, 64'd0);

    // single instruction read, minimum latency
    inst_read(32'hBFC0_0000, wc);
    check("inst_accept_cycle0", wc, 64'd0);
    wait_idle("single_read_drain");
    check("inst_latency", last_inst_ok_cyc - acc_cyc, 64'd2);

    // same-cycle arbitration: data read beats instruction read
    n0 = n_drd_ok;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 3'd2;
    #1;
    check("arb_data_addr_ok", {63'd0, data_addr_ok}, 64'd1);
    check("arb_inst_addr_ok", {63'd0, inst_addr_ok}, 64'd0);
    if (data_addr_ok) begin
      exp_ar_q.push_back({25'd0, 4'd1, 3'd2, 32'h8000_1000});
      data_exp_q.push_back({1'b0, rdata_for(32'h8000_1000)});
    end
    @(negedge clk);
    data_req = 1'b0;
    n = 0;
    #1;
    while (!inst_addr_ok && n < 50) begin @(negedge clk); #1; n++; end
    check("arb_inst_after_data", n_drd_ok, n0 + 1);
    if (inst_addr_ok) begin
      exp_ar_q.push_back({25'd0, 4'd0, 3'd2, 32'hBFC0_0100});
      inst_exp_q.push_back(rdata_for(32'hBFC0_0100));
    end
    @(negedge clk);
    inst_req = 1'b0;
    wait_idle("arb_drain");

    // write with W three cycles ahead of AW
    aw_delay = 3; w_delay = 0;
    n0 = n_wr_ok;
    data_op(1'b1, 32'h8000_2004, 3'd1, 4'h3, 32'h0000_BEEF, wc);
    wait_idle("w_before_aw_drain");
    check("w_before_aw_one_ok", n_wr_ok, n0 + 1);
    aw_delay = 0;

    // data write stalled in W_RESP while an instruction read completes
    b_delay = 10;
    n0 = n_wr_ok;
    data_op(1'b1, 32'h8000_3000, 3'd2, 4'hF, 32'h1234_5678, wc);
    inst_read(32'h0040_0000, wc);
    n = 0;
    while (inst_exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("ovl_inst_done", inst_exp_q.size(), 64'd0);
    check("ovl_write_pending", n_wr_ok, n0);
    data_op(1'b0, 32'h8000_3100, 3'd2, 4'h0, 32'h0, wc2);
    check("ovl_data_blocked", {63'd0, (wc2 > 0)}, 64'd1);
    check("ovl_accept_after_b", n_wr_ok, n0 + 1);
    wait_idle("overlap_drain");
    b_delay = 0;

    // random mix, including concurrent instruction and data traffic
    for (int i = 0; i < 24; i++) begin
      ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      a = $urandom() & 32'hFFFF_FFFC;
      case (kind)
        0: inst_read(a, wc);
        1: data_op(1'b0, a, 3'($urandom_range(0, 2)), 4'h0, 32'h0, wc);
        2: data_op(1'b1, a, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), $urandom(), wc);
        default: begin
          fork
            inst_read(a ^ 32'h0000_0100, wc);
            data_op(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 2)),
                    4'($urandom_range(0, 15)), $urandom(), wc2);
          join
        end
      endcase
      wait_idle("rnd_drain");
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;

    // reset while waiting for read data
    r_delay = 20;
    inst_read(32'h0000_1000, wc);
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_in_r", rd_state_dbg, 64'd2);
    #2;
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_4000;
    #1;
    check("mid_reset_valids", {61'd0, arvalid, rready, awvalid}, 64'd0);
    check("mid_reset_oks", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 64'd0);
    check("mid_reset_states", {60'd0, rd_state_dbg, wr_state_dbg}, 64'd0);
    inst_exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    r_delay = 0;
    repeat (3) @(negedge clk);
    check("post_reset_no_ok", inst_exp_q.size() + data_exp_q.size(), 64'd0);
    inst_read(32'hBFC0_0010, wc);
    check("post_reset_accept_cycle0", wc, 64'd0);
    wait_idle("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
